fcl_seq_ctrl: RTL and testbench
===============================

// Module: fcl_seq_ctrl
// PURPOSE
//  Sequencer for fully-connected layer 1: walks output neurons and input index, drives
//  weight/input/bias memory addresses and the enables of the dff_en accumulator and bias
//  registers, then hands each finished neuron downstream over a valid/ready handshake.
//  Sits between the layer start/done interface and the FCL MAC datapath.
// PARAMETERS
//  NUM_IN     400  inputs per neuron (>=2)
//  NUM_OUT    120  output neurons (>=1)
//  IN_AW      $clog2(NUM_IN)           input/index address width
//  OUT_AW     $clog2(NUM_OUT)          neuron/bias address width
//  WT_AW      $clog2(NUM_IN*NUM_OUT)   weight address width
// PORTS
//  fcl_clk       in   1       clock, all state on rising edge
//  fcl_rst_b     in   1       asynchronous active-low reset
//  start_i       in   1       pulse: begin layer; sampled only in IDLE
//  abort_i       in   1       sync abort: back to IDLE next cycle, no done_o
//  out_ready_i   in   1       downstream accepts neuron result
//  in_addr_o     out  IN_AW   input feature read address
//  wt_addr_o     out  WT_AW   weight read address = out_idx*NUM_IN + in_idx
//  bias_addr_o   out  OUT_AW  bias read address (= current neuron)
//  acc_clr_o     out  1       clear accumulator register
//  acc_en_o      out  1       accumulator dff_en enable (product valid)
//  bias_en_o     out  1       add-bias register enable
//  out_valid_o   out  1       neuron result valid
//  out_idx_o     out  OUT_AW  neuron index of presented result
//  busy_o        out  1       high in every state except IDLE
//  done_o        out  1       1-cycle pulse after last neuron accepted
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation discards progress.
//  - FSM: IDLE -> CLR -> MAC -> DRAIN -> BIAS -> OUT -> (CLR | DONE) ; DONE -> IDLE.
//  - IDLE: start_i=1 -> CLR, out_idx=0, wt pointer=0. start_i in other states ignored.
//  - CLR (1 cyc): acc_clr_o=1, in_idx=0.
//  - MAC (NUM_IN cyc): in_addr_o=in_idx, wt_addr_o=wt pointer; both increment each cycle.
//    Weight address from a running pointer (+1/cycle), no multiplier; never resets between
//    neurons. in_idx==NUM_IN-1 -> DRAIN.
//  - Memory read latency fixed at 1: acc_en_o is the MAC-issue strobe delayed 1 cycle,
//    so acc_en_o is high for exactly NUM_IN cycles, first one in the cycle after first issue.
//  - DRAIN (1 cyc): last acc_en_o; bias_addr_o=out_idx presented.
//  - BIAS (1 cyc): bias_en_o=1.
//  - OUT: out_valid_o=1, out_idx_o=out_idx, held stable until out_ready_i=1.
//    Transfer on valid&ready: out_idx==NUM_OUT-1 -> DONE, else out_idx+1 -> CLR.
//  - DONE (1 cyc): done_o=1, busy_o=1 -> IDLE.
//  - Per-neuron latency with ready held high: NUM_IN+4 cycles (CLR..OUT).
//  - abort_i has priority over all transitions; next cycle IDLE, pipeline strobe (acc_en_o)
//    cleared, out_valid_o dropped. abort_i in IDLE: no effect. start_i same cycle as
//    abort_i in IDLE: start wins (abort is no-op in IDLE).
//  - Counters never wrap past NUM_IN-1 / NUM_OUT-1; wt pointer ends at NUM_IN*NUM_OUT-1.
//  - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Package fcl_pkg: typedef enum logic [2:0] fcl_state_t {IDLE,CLR,MAC,DRAIN,BIAS,OUT,DONE};
//    localparams FCL_NUM_IN=400, FCL_NUM_OUT=120, FCL_RD_LAT=1.
//  - Sub-module fcl_idx_cnt (enable, clear, terminal-count flag) instanced for in_idx,
//    out_idx and wt pointer. acc_en_o delay stage built from dff_en (DATA_WIDTH=1).
// TESTING  (NUM_IN=4, NUM_OUT=3 unless noted)
//  1 Reset: assert fcl_rst_b=0 mid-MAC -> all outputs 0 same cycle, IDLE after release.
//  2 Full run, out_ready_i=1: start_i pulse -> wt_addr_o 0..11 in order, acc_en_o 4 cyc
//    per neuron, out_idx_o 0,1,2, done_o one pulse 24 cycles after start (3*(4+4)).
//  3 Backpressure: out_ready_i=0 for 5 cyc on neuron 1 -> out_valid_o/out_idx_o=1 stable,
//    no address activity, resumes with in_addr_o=0, wt_addr_o=8 after accept.
//  4 abort_i during MAC of neuron 1 -> IDLE next cycle, acc_en_o low, no done_o; new
//    start_i restarts at wt_addr_o=0.
//  5 start_i while busy -> ignored, sequence unchanged; NUM_OUT=1 -> single neuron, done_o.
//  6 Scoreboard: model MAC (sum in*wt + bias) against datapath for random mem contents.

Source files
------------

// File: rtl/fcl_pkg.sv
// Shared types and constants for the FC layer 1 sequencer.
// State encoding, control bundle and address-width helper.
package fcl_pkg;

  localparam int unsigned FCL_NUM_IN  = 400;
  localparam int unsigned FCL_NUM_OUT = 120;
  localparam int unsigned FCL_RD_LAT  = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    MAC,
    DRAIN,
    BIAS,
    OUT,
    DONE
  } fcl_state_t;

  typedef struct packed {
    logic clr;
    logic bias_en;
    logic valid;
    logic busy;
    logic done;
  } fcl_ctl_t;

  // A single-entry range still needs one address bit.
  function automatic int unsigned fcl_aw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_en.sv
// Enabled D flip-flop with asynchronous active-low reset.
// Used as the memory-latency delay stage for the MAC strobe.
module dff_en #(
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fcl_idx_cnt.sv
// Up counter with synchronous clear and terminal-count flag.
// Clear has priority over enable; saturation is left to the caller.
module fcl_idx_cnt #(
  parameter int unsigned W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == W'(MAX));

endmodule

// File: rtl/fcl_seq_ctrl.sv
// FC layer 1 sequencer: walks neurons and inputs, drives memory
// addresses and datapath enables, hands results out over valid/ready.
module fcl_seq_ctrl
  import fcl_pkg::*;
#(
  parameter int unsigned NUM_IN  = FCL_NUM_IN,
  parameter int unsigned NUM_OUT = FCL_NUM_OUT,
  parameter int unsigned IN_AW   = fcl_aw(NUM_IN),
  parameter int unsigned OUT_AW  = fcl_aw(NUM_OUT),
  parameter int unsigned WT_AW   = fcl_aw(NUM_IN * NUM_OUT)
) (
  input  logic              fcl_clk,
  input  logic              fcl_rst_b,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              out_ready_i,
  output logic [IN_AW-1:0]  in_addr_o,
  output logic [WT_AW-1:0]  wt_addr_o,
  output logic [OUT_AW-1:0] bias_addr_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic              bias_en_o,
  output logic              out_valid_o,
  output logic [OUT_AW-1:0] out_idx_o,
  output logic              busy_o,
  output logic              done_o
);

  fcl_state_t state, state_d;
  fcl_ctl_t   ctl_q, ctl_d;

  logic [IN_AW-1:0]  in_idx;
  logic [OUT_AW-1:0] out_idx;
  logic [WT_AW-1:0]  wt_ptr;
  logic              in_tc, out_tc, wt_tc;
  logic              in_clr, in_en;
  logic              run_go, out_en, wt_en;
  logic [FCL_RD_LAT:0] iss;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start_i) state_d = CLR;
      CLR:     state_d = MAC;
      MAC:     if (in_tc) state_d = DRAIN;
      DRAIN:   state_d = BIAS;
      BIAS:    state_d = OUT;
      OUT:     if (out_ready_i) state_d = out_tc ? DONE : CLR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && state != IDLE) state_d = IDLE;
  end

  always_comb begin
    ctl_d         = '0;
    ctl_d.clr     = (state_d == CLR);
    ctl_d.bias_en = (state_d == BIAS);
    ctl_d.valid   = (state_d == OUT);
    ctl_d.busy    = (state_d != IDLE);
    ctl_d.done    = (state_d == DONE);
  end

  always_ff @(posedge fcl_clk or negedge fcl_rst_b) begin
    if (!fcl_rst_b) begin
      state <= IDLE;
      ctl_q <= '0;
    end else begin
      state <= state_d;
      ctl_q <= ctl_d;
    end
  end

  assign run_go = (state == IDLE) && start_i;
  assign in_clr = (state_d == CLR);
  assign in_en  = (state == MAC) && !in_tc;
  assign out_en = (state == OUT) && out_ready_i
               && !out_tc && !abort_i;
  // Weight pointer runs across neurons; it steps on accept
  // so the last MAC issue of a neuron holds its address.
  assign wt_en  = ((state == MAC) && !in_tc || out_en)
               && !wt_tc;

  fcl_idx_cnt #(.W(IN_AW), .MAX(NUM_IN - 1)) u_in_cnt (
    .clk   (fcl_clk),
    .rst_n (fcl_rst_b),
    .clr   (in_clr),
    .en    (in_en),
    .cnt   (in_idx),
    .tc    (in_tc)
  );

  fcl_idx_cnt #(.W(OUT_AW), .MAX(NUM_OUT - 1)) u_out_cnt (
    .clk   (fcl_clk),
    .rst_n (fcl_rst_b),
    .clr   (run_go),
    .en    (out_en),
    .cnt   (out_idx),
    .tc    (out_tc)
  );

  fcl_idx_cnt #(.W(WT_AW), .MAX(NUM_IN * NUM_OUT - 1)) u_wt_cnt (
    .clk   (fcl_clk),
    .rst_n (fcl_rst_b),
    .clr   (run_go),
    .en    (wt_en),
    .cnt   (wt_ptr),
    .tc    (wt_tc)
  );

  // Product-valid strobe trails the issue by the read latency.
  assign iss[0] = (state == MAC);

  for (genvar g = 0; g < FCL_RD_LAT; g++) begin : g_lat
    dff_en #(.DATA_WIDTH(1)) u_lat (
      .clk   (fcl_clk),
      .rst_n (fcl_rst_b),
      .en    (1'b1),
      .d     (iss[g] & ~abort_i),
      .q     (iss[g+1])
    );
  end

  assign in_addr_o   = in_idx;
  assign wt_addr_o   = wt_ptr;
  assign bias_addr_o = out_idx;
  assign out_idx_o   = out_idx;
  assign acc_en_o    = iss[FCL_RD_LAT];
  assign acc_clr_o   = ctl_q.clr;
  assign bias_en_o   = ctl_q.bias_en;
  assign out_valid_o = ctl_q.valid;
  assign busy_o      = ctl_q.busy;
  assign done_o      = ctl_q.done;

endmodule

// File: tb/tb_fcl_seq_ctrl.sv
// Directed bench for fcl_seq_ctrl (NUM_IN=4, NUM_OUT=3 and 1).
// Includes a small MAC datapath to score results.
module tb_fcl_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, ready;
  logic start1;

  logic [1:0] in_addr, bias_addr, out_idx;
  logic [3:0] wt_addr;
  logic       acc_clr, acc_en, bias_en, out_valid, busy, done;

  logic [1:0] in_addr1, wt_addr1;
  logic [0:0] bias_addr1, out_idx1;
  logic       acc_clr1, acc_en1, bias_en1, out_valid1, busy1, done1;

  int n_vec = 0;
  int n_err = 0;

  fcl_seq_ctrl #(
    .NUM_IN(4), .NUM_OUT(3), .IN_AW(2), .OUT_AW(2), .WT_AW(4)
  ) dut (
    .fcl_clk     (clk),
    .fcl_rst_b   (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .out_ready_i (ready),
    .in_addr_o   (in_addr),
    .wt_addr_o   (wt_addr),
    .bias_addr_o (bias_addr),
    .acc_clr_o   (acc_clr),
    .acc_en_o    (acc_en),
    .bias_en_o   (bias_en),
    .out_valid_o (out_valid),
    .out_idx_o   (out_idx),
    .busy_o      (busy),
    .done_o      (done)
  );

  fcl_seq_ctrl #(
    .NUM_IN(4), .NUM_OUT(1), .IN_AW(2), .OUT_AW(1), .WT_AW(2)
  ) dut1 (
    .fcl_clk     (clk),
    .fcl_rst_b   (rst_n),
    .start_i     (start1),
    .abort_i     (1'b0),
    .out_ready_i (1'b1),
    .in_addr_o   (in_addr1),
    .wt_addr_o   (wt_addr1),
    .bias_addr_o (bias_addr1),
    .acc_clr_o   (acc_clr1),
    .acc_en_o    (acc_en1),
    .bias_en_o   (bias_en1),
    .out_valid_o (out_valid1),
    .out_idx_o   (out_idx1),
    .busy_o      (busy1),
    .done_o      (done1)
  );

  wire [15:0] all_o = {in_addr, wt_addr, bias_addr, acc_clr,
                       acc_en, bias_en, out_valid, out_idx,
                       busy, done};
  wire [10:0] all1 = {in_addr1, wt_addr1, bias_addr1, acc_clr1,
                      acc_en1, bias_en1, out_valid1, out_idx1,
                      busy1, done1};
  wire [5:0] strb = {acc_clr, acc_en, bias_en, out_valid,
                     done, busy};

  // Datapath with 1-cycle read memories, driven by the DUT strobes.
  logic [7:0] in_mem [4];
  logic [7:0] wt_mem [16];
  logic [7:0] b_mem  [4];
  logic [7:0] rd_in, rd_wt, rd_b;
  int acc = 0;
  int res = 0;

  always @(posedge clk) begin
    rd_in <= in_mem[in_addr];
    rd_wt <= wt_mem[wt_addr];
    rd_b  <= b_mem[bias_addr];
    if (acc_clr) acc <= 0;
    else if (acc_en) acc <= acc + int'(rd_in) * int'(rd_wt);
    if (bias_en) res <= acc + int'(rd_b);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (all_o !== 16'h0 || all1 !== 11'h0) begin
      n_err++;
      $display("FAIL reset_hold got %h/%h want 0", all_o, all1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (all_o !== 16'h0) begin
      n_err++;
      $display("FAIL reset_idle got %h want 0", all_o);
    end
    pulse_start();
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || in_addr !== 2'd1 || wt_addr !== 4'd1) begin
      n_err++;
      $display("FAIL reset_premac busy=%b in=%0d wt=%0d want 1/1/1",
               busy, in_addr, wt_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (all_o !== 16'h0) begin
      n_err++;
      $display("FAIL reset_async got %h want 0", all_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (all_o !== 16'h0) begin
      n_err++;
      $display("FAIL reset_release got %h want 0", all_o);
    end
  endtask

  task automatic test_full_run();
    int k, p;
    logic [5:0] e;
    ready = 1'b1;
    pulse_start();
    for (int n = 1; n <= 26; n++) begin
      k = (n - 1) / 8;
      p = (n - 1) % 8;
      if (n <= 24) e = {p == 0, p >= 2 && p <= 5, p == 6, p == 7,
                        1'b0, 1'b1};
      else         e = {4'b0, n == 25, n == 25};
      n_vec++;
      if (strb !== e) begin
        n_err++;
        $display("FAIL full_strb n=%0d got %b want %b", n, strb, e);
      end
      if (n <= 24 && p >= 1 && p <= 4) begin
        n_vec++;
        if (in_addr !== 2'(p - 1) || wt_addr !== 4'(4 * k + p - 1)) begin
          n_err++;
          $display("FAIL full_addr n=%0d got %0d/%0d want %0d/%0d",
                   n, in_addr, wt_addr, p - 1, 4 * k + p - 1);
        end
      end
      if (n <= 24 && p == 7) begin
        n_vec++;
        if (out_idx !== 2'(k) || bias_addr !== 2'(k)) begin
          n_err++;
          $display("FAIL full_idx n=%0d got %0d want %0d",
                   n, out_idx, k);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int from, input int want, input string nm);
    int dn = -1;
    for (int n = from; n <= from + 60 && dn < 0; n++) begin
      if (done === 1'b1) dn = n;
      else @(negedge clk);
    end
    n_vec++;
    if (dn != want) begin
      n_err++;
      $display("FAIL %s done_cycle got %0d want %0d", nm, dn, want);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    ready = 1'b1;
    pulse_start();
    repeat (8) @(negedge clk);
    ready = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({out_valid, out_idx, in_addr, wt_addr, acc_en, acc_clr,
           bias_en} !== {1'b1, 2'd1, 2'd3, 4'd7, 3'b000}) begin
        n_err++;
        $display("FAIL bp_stall i=%0d v=%b idx=%0d in=%0d wt=%0d en=%b",
                 i, out_valid, out_idx, in_addr, wt_addr, acc_en);
      end
      if (i < 4) @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({acc_clr, out_valid, in_addr, wt_addr} !== {2'b10, 2'd0, 4'd8}) begin
      n_err++;
      $display("FAIL bp_resume_clr clr=%b v=%b in=%0d wt=%0d want 1/0/0/8",
               acc_clr, out_valid, in_addr, wt_addr);
    end
    @(negedge clk);
    n_vec++;
    if (in_addr !== 2'd0 || wt_addr !== 4'd8) begin
      n_err++;
      $display("FAIL bp_resume_mac in=%0d wt=%0d want 0/8",
               in_addr, wt_addr);
    end
    wait_done(22, 29, "bp");
  endtask

  task automatic test_abort();
    int nd = 0;
    ready = 1'b1;
    pulse_start();
    repeat (10) @(negedge clk);
    n_vec++;
    if (in_addr !== 2'd1 || wt_addr !== 4'd5) begin
      n_err++;
      $display("FAIL abort_pre in=%0d wt=%0d want 1/5", in_addr, wt_addr);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if ({busy, acc_en, out_valid, acc_clr} !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_idle busy=%b en=%b v=%b want 0",
               busy, acc_en, out_valid);
    end
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      @(negedge clk);
    end
    n_vec++;
    if (nd != 0) begin
      n_err++;
      $display("FAIL abort_quiet got %0d active cycles want 0", nd);
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || acc_clr !== 1'b1) begin
      n_err++;
      $display("FAIL abort_start_wins busy=%b clr=%b want 1/1",
               busy, acc_clr);
    end
    @(negedge clk);
    n_vec++;
    if (in_addr !== 2'd0 || wt_addr !== 4'd0) begin
      n_err++;
      $display("FAIL abort_restart in=%0d wt=%0d want 0/0",
               in_addr, wt_addr);
    end
    wait_done(2, 25, "abort_rerun");
  endtask

  task automatic test_start_busy();
    ready = 1'b1;
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    n_vec++;
    if (acc_clr !== 1'b1 || out_idx !== 2'd1) begin
      n_err++;
      $display("FAIL busy_start clr=%b idx=%0d want 1/1", acc_clr, out_idx);
    end
    @(negedge clk);
    n_vec++;
    if (wt_addr !== 4'd4) begin
      n_err++;
      $display("FAIL busy_wt got %0d want 4", wt_addr);
    end
    wait_done(10, 25, "busy");
  endtask

  task automatic test_single();
    logic [3:0] e;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      e = {n == 1, n >= 3 && n <= 6, n == 8, n == 9};
      n_vec++;
      if ({acc_clr1, acc_en1, out_valid1, done1} !== e) begin
        n_err++;
        $display("FAIL single_strb n=%0d got %b want %b", n,
                 {acc_clr1, acc_en1, out_valid1, done1}, e);
      end
      if (n == 5) begin
        n_vec++;
        if (wt_addr1 !== 2'd3) begin
          n_err++;
          $display("FAIL single_wt got %0d want 3", wt_addr1);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_scoreboard();
    int exp_r [3];
    int got = 0;
    bit seen = 0;
    for (int i = 0; i < 4; i++) in_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) wt_mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) b_mem[i] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      exp_r[k] = int'(b_mem[k]);
      for (int i = 0; i < 4; i++)
        exp_r[k] += int'(in_mem[i]) * int'(wt_mem[4 * k + i]);
    end
    pulse_start();
    for (int c = 0; c < 400 && !seen; c++) begin
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        ready = 1'($urandom_range(0, 1));
        if (out_valid === 1'b1 && ready) begin
          n_vec++;
          if (res !== exp_r[out_idx]) begin
            n_err++;
            $display("FAIL sb_result idx=%0d got %0d want %0d",
                     out_idx, res, exp_r[out_idx]);
          end
          got++;
        end
        @(negedge clk);
      end
    end
    n_vec++;
    if (!seen || got != 3) begin
      n_err++;
      $display("FAIL sb_count done=%0b got %0d results want 3", seen, got);
    end
    ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    ready  = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) in_mem[i] = 8'(i + 1);
    for (int i = 0; i < 16; i++) wt_mem[i] = 8'(i);
    for (int i = 0; i < 4; i++) b_mem[i] = 8'(10 * i);
    @(negedge clk);
    test_reset();
    test_full_run();
    test_backpressure();
    test_abort();
    test_start_busy();
    test_single();
    test_scoreboard();
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
